// File: rtl/cpu_programmer_pkg.sv
// Shared constants for the CPU programmer: FSM encoding, default load sizing
// and the bit positions of the CPU control signals on its uio bus.
package cpu_programmer_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PREFETCH  = 3'd1,
    ST_LOAD      = 3'd2,
    ST_WAIT_DONE = 3'd3,
    ST_DONE      = 3'd4,
    ST_ERROR     = 3'd5
  } state_e;

  localparam int DEF_NUM_BYTES    = 16;
  localparam int DEF_DONE_TIMEOUT = 64;
  localparam int CNT_W            = 5;

  // CPU control-block pin mapping on the uio bus
  localparam int UIO_PROG_BIT  = 0;
  localparam int UIO_READY_BIT = 1;
  localparam int UIO_DONE_BIT  = 2;

  function automatic logic state_is_busy(input state_e s);
    return (s == ST_PREFETCH) || (s == ST_LOAD) || (s == ST_WAIT_DONE);
  endfunction

endpackage

// File: rtl/byte_fifo2.sv
// Two-entry byte FIFO holding program bytes between the host source and the CPU.
// The head is presented combinationally; an empty FIFO reads as 8'h00.
module byte_fifo2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       clr_i,
  input  logic       push_i,
  input  logic       pop_i,
  input  logic [7:0] data_i,
  output logic [7:0] data_o,
  output logic       full_o,
  output logic       empty_o
);

  logic [7:0] mem_q [2];
  logic       wr_ptr_q;
  logic       rd_ptr_q;
  logic [1:0] count_q;
  logic       do_push;
  logic       do_pop;

  assign full_o  = (count_q == 2'd2);
  assign empty_o = (count_q == 2'd0);
  assign do_push = push_i && !full_o;
  assign do_pop  = pop_i && !empty_o;
  assign data_o  = empty_o ? 8'h00 : mem_q[rd_ptr_q];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mem_q[0] <= 8'h00;
      mem_q[1] <= 8'h00;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else if (clr_i) begin
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (do_push) begin
        mem_q[wr_ptr_q] <= data_i;
        wr_ptr_q        <= !wr_ptr_q;
      end
      if (do_pop) rd_ptr_q <= !rd_ptr_q;
      case ({do_push, do_pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/cpu_programmer.sv
// Streams NUM_BYTES program bytes from a host source into a CPU's RAM through
// its programming-mode handshake, then waits for the CPU to confirm the load.
module cpu_programmer
  import cpu_programmer_pkg::*;
#(
  parameter int NUM_BYTES    = DEF_NUM_BYTES,
  parameter int DONE_TIMEOUT = DEF_DONE_TIMEOUT
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [7:0]       src_data,
  input  logic             src_valid,
  output logic             src_ready,
  output logic [7:0]       prog_data,
  output logic             programming,
  input  logic             cpu_ready,
  input  logic             cpu_done,
  output logic             busy,
  output logic             done,
  output logic             error,
  output logic [CNT_W-1:0] byte_count,
  output state_e           dbg_state_o
);

  localparam int               TMR_W    = $clog2(DONE_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] NB       = CNT_W'(NUM_BYTES);
  localparam logic [TMR_W-1:0] TMO_LAST = TMR_W'(DONE_TIMEOUT - 1);

  state_e           state_q;
  logic [CNT_W-1:0] byte_count_q;
  logic [CNT_W-1:0] fetched_q;
  logic [TMR_W-1:0] timer_q;
  logic             done_q;
  logic             error_q;
  logic             fifo_full;
  logic             fifo_empty;
  logic             can_start;
  logic             push;
  logic             pop;
  logic             primed;

  // Handshakes: a source byte transfers on any rising edge where src_valid and
  // src_ready are both high; the CPU takes prog_data on any edge with cpu_ready
  // high in LOAD, and an empty FIFO at that moment is an underrun.
  assign can_start   = start && (state_q inside {ST_IDLE, ST_DONE, ST_ERROR});
  assign busy        = state_is_busy(state_q);
  assign programming = (state_q == ST_LOAD) || (state_q == ST_WAIT_DONE);
  assign src_ready   = busy && !fifo_full && (fetched_q < NB);
  assign push        = src_valid && src_ready;
  assign pop         = (state_q == ST_LOAD) && cpu_ready && !fifo_empty;
  assign primed      = fifo_full || ((NUM_BYTES == 1) && !fifo_empty);

  assign done        = done_q;
  assign error       = error_q;
  assign byte_count  = byte_count_q;
  assign dbg_state_o = state_q;

  byte_fifo2 u_fifo (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr_i   (can_start),
    .push_i  (push),
    .pop_i   (pop),
    .data_i  (src_data),
    .data_o  (prog_data),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      byte_count_q <= '0;
      fetched_q    <= '0;
      timer_q      <= '0;
      done_q       <= 1'b0;
      error_q      <= 1'b0;
    end else begin
      if (push) fetched_q <= fetched_q + 1'b1;
      case (state_q)
        ST_IDLE, ST_DONE, ST_ERROR: begin
          if (can_start) begin
            state_q      <= ST_PREFETCH;
            byte_count_q <= '0;
            fetched_q    <= '0;
            timer_q      <= '0;
            done_q       <= 1'b0;
            error_q      <= 1'b0;
          end
        end
        ST_PREFETCH: begin
          if (primed) state_q <= ST_LOAD;
        end
        ST_LOAD: begin
          if (cpu_ready) begin
            if (fifo_empty) begin
              state_q <= ST_ERROR;
              error_q <= 1'b1;
            end else begin
              if (byte_count_q < NB) byte_count_q <= byte_count_q + 1'b1;
              if (byte_count_q >= NB - 1'b1) begin
                state_q <= ST_WAIT_DONE;
                timer_q <= '0;
              end
            end
          end
        end
        ST_WAIT_DONE: begin
          // A further byte request means the CPU expects a longer program.
          if (cpu_ready) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
          end else if (cpu_done) begin
            state_q <= ST_DONE;
            done_q  <= 1'b1;
          end else if (timer_q == TMO_LAST) begin
            state_q <= ST_ERROR;
            error_q <= 1'b1;
          end else begin
            timer_q <= timer_q + 1'b1;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_cpu_programmer.sv
// Bench for cpu_programmer: scenario table driven through a cycle-stepped
// source/CPU model, byte order checked through an expected-byte queue.
module tb_cpu_programmer;
  import cpu_programmer_pkg::*;

  localparam int NB     = 16;
  localparam int TMO    = 64;
  localparam int BUDGET = 600;

  logic       clk = 1'b0;
  logic       rst_n = 1'b1;
  logic       start = 1'b0;
  logic [7:0] src_data = 8'h00;
  logic       src_valid = 1'b0;
  logic       cpu_ready = 1'b0;
  logic       cpu_done = 1'b0;
  logic       src_ready;
  logic [7:0] prog_data;
  logic       programming;
  logic       busy;
  logic       done;
  logic       error;
  logic [4:0] byte_count;
  state_e     dbg_state;

  int n_cmp = 0;
  int n_err = 0;
  logic [7:0] exp_q[$];

  typedef struct {
    int period;
    int withhold;
    int done_delay;
    bit rand_data;
    bit inject;
    int reset_at;
    bit exp_done;
    bit exp_error;
    int exp_count;
  } scen_t;

  scen_t table_q [6];

  cpu_programmer #(.NUM_BYTES(NB), .DONE_TIMEOUT(TMO)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .start       (start),
    .src_data    (src_data),
    .src_valid   (src_valid),
    .src_ready   (src_ready),
    .prog_data   (prog_data),
    .programming (programming),
    .cpu_ready   (cpu_ready),
    .cpu_done    (cpu_done),
    .busy        (busy),
    .done        (done),
    .error       (error),
    .byte_count  (byte_count),
    .dbg_state_o (dbg_state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_state"},       32'(dbg_state),   32'(ST_IDLE));
    check({tag, "_programming"}, 32'(programming), 32'd0);
    check({tag, "_src_ready"},   32'(src_ready),   32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    check({tag, "_done"},        32'(done),        32'd0);
    check({tag, "_error"},       32'(error),       32'd0);
    check({tag, "_byte_count"},  32'(byte_count),  32'd0);
    check({tag, "_prog_data"},   32'(prog_data),   32'd0);
  endtask

  // One cycle per iteration: observe at the falling edge, then drive inputs
  // that the DUT sees at the following rising edge (edge number == cyc).
  task automatic run_scen(input scen_t s, input string tag);
    int occ = 0;
    int consumed = 0;
    int src_ptr = 0;
    int last_pop = -1;
    int obs = -1;
    bit underrun = 0;
    bit inj_start = 0;
    bit inj_done = 0;
    bit pushed;
    logic [7:0] bytes [NB];
    exp_q.delete();
    for (int i = 0; i < NB; i++)
      bytes[i] = s.rand_data ? 8'($urandom_range(0, 255)) : 8'(8'h10 + i);
    @(negedge clk);
    start = 1'b1;
    for (int cyc = 0; cyc < BUDGET; cyc++) begin
      @(negedge clk);
      if (done || error) begin
        obs = cyc;
        break;
      end
      start = 1'b0; cpu_ready = 1'b0; cpu_done = 1'b0; src_valid = 1'b0; src_data = 8'h00;
      if (s.reset_at >= 0 && consumed == s.reset_at) begin
        check({tag, "_pre_rst_count"}, 32'(byte_count), 32'(s.reset_at));
        #2 rst_n = 1'b0;
        #1 check_reset_values({tag, "_async"});
        @(negedge clk);
        rst_n = 1'b1;
        return;
      end
      if (src_ptr < NB && !(s.withhold >= 0 && src_ptr == s.withhold)) begin
        src_valid = 1'b1;
        src_data  = bytes[src_ptr];
      end
      pushed = src_valid && src_ready;
      if (programming && consumed < NB && (cyc % s.period) == 0) begin
        cpu_ready = 1'b1;
        if (occ > 0) begin
          check($sformatf("%s_order_%0d", tag, consumed), 32'(prog_data), 32'(exp_q.pop_front()));
          consumed++;
          occ--;
          if (consumed == NB) last_pop = cyc;
        end else begin
          check({tag, "_underrun_prog_data"}, 32'(prog_data), 32'd0);
          underrun = 1;
        end
      end
      if (pushed) begin
        exp_q.push_back(src_data);
        occ++;
        src_ptr++;
      end
      if (s.done_delay >= 0 && last_pop >= 0 && cyc == last_pop + s.done_delay) cpu_done = 1'b1;
      if (s.inject && !inj_done && busy && !programming) begin
        cpu_done = 1'b1;
        inj_done = 1;
      end
      if (s.inject && !inj_start && programming && consumed == 5) begin
        start = 1'b1;
        inj_start = 1;
      end
    end
    start = 1'b0; cpu_ready = 1'b0; cpu_done = 1'b0; src_valid = 1'b0;
    if (obs < 0) check({tag, "_finished_within_budget"}, 32'd0, 32'd1);
    check({tag, "_done"},        32'(done),        32'(s.exp_done));
    check({tag, "_error"},       32'(error),       32'(s.exp_error));
    check({tag, "_byte_count"},  32'(byte_count),  32'(s.exp_count));
    check({tag, "_programming"}, 32'(programming), 32'd0);
    check({tag, "_busy"},        32'(busy),        32'd0);
    if (s.exp_done) check({tag, "_done_latency"}, 32'(obs - 1 - last_pop), 32'(s.done_delay));
    if (s.exp_error && s.exp_count == NB)
      check({tag, "_timeout_latency"}, 32'(obs - 1 - last_pop), 32'(TMO));
    if (s.withhold >= 0) check({tag, "_underrun_seen"}, 32'(underrun), 32'd1);
  endtask

  initial begin
    //            period wh  dd  rnd  inj  rst  done err  count
    table_q[0] = '{3,   -1,  2, 1'b0, 1'b0, -1, 1'b1, 1'b0, 16};
    table_q[1] = '{1,   -1,  1, 1'b0, 1'b0, -1, 1'b1, 1'b0, 16};
    table_q[2] = '{3,    4, -1, 1'b0, 1'b0, -1, 1'b0, 1'b1, 4};
    table_q[3] = '{3,   -1, -1, 1'b0, 1'b0, -1, 1'b0, 1'b1, 16};
    table_q[4] = '{2,   -1,  5, 1'b1, 1'b0, -1, 1'b1, 1'b0, 16};
    table_q[5] = '{3,   -1,  2, 1'b0, 1'b1, -1, 1'b1, 1'b0, 16};

    #1 rst_n = 1'b0;
    #2 check_reset_values("por");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;

    for (int t = 0; t < 6; t++) run_scen(table_q[t], $sformatf("s%0d", t));

    run_scen('{3, -1, -1, 1'b0, 1'b0, 7, 1'b0, 1'b0, 0}, "rst_mid");
    check_reset_values("post_rst");
    run_scen(table_q[0], "reload");

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule

// File: doc/cpu_programmer.md
CPU_PROGRAMMER -- requirements
Module: cpu_programmer

Interface
REQ-001: Parameter NUM_BYTES, default 16; number of program bytes loaded into CPU RAM.
REQ-002: Parameter DONE_TIMEOUT, default 64; cycles allowed between last byte consumed and cpu_done.
REQ-003: clk  in  1  single clock; all state updates on rising edge.
REQ-004: rst_n  in  1  reset, asynchronous assert, active-low.
REQ-005: start  in  1  one-cycle request to begin a load; ignored unless in IDLE, DONE or ERROR.
REQ-006: src_data  in  8  next program byte from host source.
REQ-007: src_valid  in  1  src_data valid.
REQ-008: src_ready  out  1  byte accepted on a cycle with src_valid & src_ready.
REQ-009: prog_data  out  8  byte driven to CPU ui_in.
REQ-010: programming  out  1  CPU programming-mode request (to CPU uio_in[0]).
REQ-011: cpu_ready  in  1  CPU ready-for-byte (from CPU uio_out[1]); CPU samples prog_data on the same rising edge.
REQ-012: cpu_done  in  1  CPU done-loading (from CPU uio_out[2]).
REQ-013: busy  out  1  load in progress.
REQ-014: done  out  1  load completed successfully; held until next start.
REQ-015: error  out  1  load aborted (underrun or timeout); held until next start.
REQ-016: byte_count  out  5  bytes consumed by CPU in current load.

Function
REQ-017: Holding buffer: 2-entry FIFO of bytes; src_ready = busy & FIFO not full & fetched < NUM_BYTES.
REQ-018: prog_data = FIFO head when non-empty, else 8'h00.
REQ-019: States: IDLE, PREFETCH, LOAD, WAIT_DONE, DONE, ERROR.
REQ-020: IDLE/DONE/ERROR + start -> PREFETCH; clears FIFO, byte_count, fetched count, done, error.
REQ-021: PREFETCH: programming=0; -> LOAD the cycle after FIFO holds 2 bytes, or 1 byte if NUM_BYTES==1.
REQ-022: LOAD: programming=1; each cycle with cpu_ready=1 and FIFO non-empty pops head and increments byte_count.
REQ-023: LOAD: cpu_ready=1 with FIFO empty -> ERROR (underrun); no pop, no increment.
REQ-024: Simultaneous push and pop in one cycle permitted; occupancy unchanged.
REQ-025: Pop that makes byte_count == NUM_BYTES -> WAIT_DONE next cycle; timeout counter cleared.
REQ-026: WAIT_DONE: programming=1; cpu_done=1 -> DONE; counter reaching DONE_TIMEOUT without cpu_done -> ERROR.
REQ-027: cpu_ready in WAIT_DONE -> ERROR (CPU requested more bytes than NUM_BYTES).
REQ-028: DONE, ERROR, IDLE: programming=0, src_ready=0.
REQ-029: busy = state in {PREFETCH, LOAD, WAIT_DONE}.
REQ-030: cpu_done in any state other than WAIT_DONE is ignored.
REQ-031: start while busy is ignored; no restart mid-load.
REQ-032: byte_count saturates at NUM_BYTES; no wrap.

Reset
REQ-033: rst_n low -> state IDLE, FIFO empty, all counters 0, programming=0, src_ready=0, busy=0, done=0, error=0, prog_data=8'h00, immediately without clock.
REQ-034: Reset mid-load aborts silently; error not set; CPU sees programming fall.

Structure
REQ-035: State encoding and default NUM_BYTES/DONE_TIMEOUT constants live in a shared package with the CPU control-block constants.
REQ-036: Holding buffer is one sub-module, byte_fifo2 (depth 2, width 8, push/pop/full/empty).
REQ-037: No tri-state drivers; prog_data connects to CPU ui_in directly.

Verification
REQ-038: start, source bytes 0x10..0x1F always valid, cpu_ready pulsed every 3 cycles, cpu_done 2 cycles after 16th pop -> CPU sees 0x10..0x1F in order, done=1, byte_count=16.
REQ-039: Source withholds byte 5 until after cpu_ready asserts with FIFO empty -> error=1, byte_count=4, programming=0 next cycle.
REQ-040: All 16 bytes consumed, cpu_done never asserted -> error=1 exactly DONE_TIMEOUT cycles after WAIT_DONE entry.
REQ-041: rst_n low at byte_count=7 -> all outputs at reset values asynchronously; new start reloads from byte 0.
REQ-042: cpu_ready held high continuously with source valid every cycle -> one byte per cycle, no underrun, order preserved.
REQ-043: start pulsed during LOAD and cpu_done pulsed in PREFETCH -> both ignored; load completes normally.
